ptl_link_arbiter: RTL and testbench
===================================

# ptl_link_arbiter

Clocked scheduler that shares one passive-transmission-line (PTL) link between several requesters. Each granted request becomes exactly one SFQ pulse on the link. The pulse is encoded as a single transition (toggle) of the line, the same edge-per-pulse convention the PTL receiver cells use. The block enforces a start-up blanking window and a minimum pulse spacing so the receiver's hold constraint is never violated. It sits between the digital request sources and the PTL driver, in the link front end.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16).
- GAP_CYCLES, 2, idle clock cycles forced between successive grants (0..255).
- START_CYCLES, 8, cycles after reset release during which no grant is issued (0..255).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  level request per requester; held high until granted.
- grant  output  N_REQ  one-hot, one-cycle grant pulse.
- q  output  1  PTL drive line; toggles once per granted pulse.
- busy  output  1  high while in WARMUP or GUARD.
- tx_id  output  clog2(N_REQ)  index of the most recent winner.

## Operation
- States:
  - WARMUP: entered on reset. A counter loads START_CYCLES and decrements each cycle. Goes to IDLE when the counter is 0. If START_CYCLES=0, the first cycle after reset is IDLE.
  - IDLE: if any req bit is high, pick a winner, assert grant[winner], toggle q, load tx_id, then go to GUARD. If GAP_CYCLES=0, stay in IDLE instead and accept a new grant on the next cycle.
  - GUARD: the gap counter loads GAP_CYCLES at the grant and decrements each cycle. No grants in this state. Goes to IDLE when the counter reaches 0.
- Winner selection is round-robin. Search starts at pointer ptr and proceeds upward, wrapping from N_REQ-1 to 0. The first requester with req high wins. After the grant, ptr = (winner+1) mod N_REQ.
- Handshake:
  - A requester holds req until it sees grant, then drops req on the following cycle.
  - If req is still high after the guard window, it is treated as a new request and competes normally under round-robin.
  - A req withdrawn before it is granted is discarded, with no pulse and no error.
- q is toggled only on a grant. Each edge (rising or falling) is one pulse. q never toggles twice within GAP_CYCLES+1 cycles.
- Reset values: state=WARMUP, grant=0, q=0, busy=1, tx_id=0, ptr=0, counters loaded as above.
- Reset asserted mid-operation (including during GUARD or on the same edge as a grant) wins. All outputs return to reset values immediately, and any in-flight grant is lost.
- Simultaneous requests: only one grant per cycle. The others stay pending under their held req.

## Timing
- Latency: req is sampled high at edge k in IDLE. grant, the q toggle and tx_id update appear as registered outputs after edge k and stay for one cycle.
- Minimum spacing: for a grant at cycle t, the earliest next grant is at cycle t+GAP_CYCLES+1.
- First possible grant: cycle START_CYCLES after rst deasserts, counting the first post-reset edge as cycle 0.
- busy is registered and aligned with the state. It is low exactly in the cycles where a grant may issue.
- Worst-case wait for a held req: N_REQ*(GAP_CYCLES+1) cycles once IDLE is reached.

## Configuration
- PTL_ARB_CNT_EN defined: adds output tx_count, a 16-bit counter.
  - Resets to 0.
  - Increments by 1 on every grant.
  - Saturates at 16'hFFFF.
- PTL_ARB_CNT_EN undefined: the tx_count port and its logic are absent. All other behaviour is identical.

## Test plan
- Start-up: START_CYCLES=8, req=4'b0001 held from reset release. No grant in cycles 0..7. grant=4'b0001 and q goes 0→1 in cycle 8, with busy low in cycle 8 only.
- Round-robin: GAP_CYCLES=2, req=4'b1111 held. Grants go 0,1,2,3,0 at cycles t, t+3, t+6, t+9, t+12, and q toggles at each.
- Spacing: GAP_CYCLES=0, req=4'b0101 held. Grants alternate 0,2,0,2 on consecutive cycles, and q toggles every cycle.
- Withdrawal: req[3] pulses high for one cycle during GUARD. There is no grant to 3, q is unchanged, and ptr is unaffected.
- Mid-operation reset: assert rst in GUARD with q=1. q=0, grant=0, busy=1 and tx_id=0 immediately (asynchronously). WARMUP restarts.
- Counter (PTL_ARB_CNT_EN): 70000 grants with GAP_CYCLES=0. tx_count=16'hFFFF and holds.

Source files
------------

// File: rtl/ptl_link_arbiter.sv
// Round-robin scheduler: one PTL edge per grant, with warm-up and guard gaps.
// Optional PTL_ARB_CNT_EN adds a saturating 16-bit tx_count output.
module ptl_link_arbiter #(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int START_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           grant,
  output logic                       q,
  output logic                       busy,
`ifdef PTL_ARB_CNT_EN
  output logic [15:0]                tx_count,
`endif
  output logic [$clog2(N_REQ)-1:0]   tx_id
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES);
  localparam logic [7:0] START_LD = 8'(START_CYCLES);
  localparam logic [IDW:0] NR = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    WARMUP,
    IDLE,
    GUARD
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             q_q, q_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             busy_q, busy_d;

  logic             win_open;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW:0]     sum;

  // Search upward from ptr, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (sum >= NR) begin
        sum = sum - NR;
      end
      if (!found && req[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  // state_q is the phase of the current cycle; a grant is
  // issued on the edge that opens an IDLE cycle.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    ptr_d    = ptr_q;
    grant_d  = '0;
    q_d      = q_q;
    id_d     = id_q;
    win_open = 1'b0;

    unique case (state_q)
      WARMUP: begin
        if (wcnt_q == 8'd0) begin
          win_open = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      IDLE: begin
        if (|grant_q && GAP_CYCLES != 0) begin
          state_d = GUARD;
          gcnt_d  = gcnt_q - 8'd1;
        end else begin
          win_open = 1'b1;
        end
      end
      GUARD: begin
        if (gcnt_q == 8'd0) begin
          win_open = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      default: begin
        state_d = WARMUP;
      end
    endcase

    if (win_open) begin
      state_d = IDLE;
      if (found) begin
        grant_d[win] = 1'b1;
        q_d          = ~q_q;
        id_d         = win;
        ptr_d        = (win == LAST) ? '0 : win + 1'b1;
        gcnt_d       = GAP_LD;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WARMUP;
      wcnt_q  <= START_LD;
      gcnt_q  <= GAP_LD;
      ptr_q   <= '0;
      grant_q <= '0;
      q_q     <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      q_q     <= q_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign q     = q_q;
  assign busy  = busy_q;
  assign tx_id = id_q;

`ifdef PTL_ARB_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (|grant_d && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tx_count = cnt_q;
`endif

  a_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(grant_q));

  a_edge_per_grant: assert property (
    @(posedge clk) disable iff (rst)
    (q_q != $past(q_q)) == (|grant_q));

endmodule

// File: tb/tb_ptl_link_arbiter.sv
// Scoreboard bench for ptl_link_arbiter: two instances with different
// start-up and gap settings, directed request vectors.
module tb_ptl_link_arbiter;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic       q;
    logic [1:0] id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] g_a, g_b;
  logic       q_a, q_b;
  logic       busy_a, busy_b;
  logic [1:0] id_a, id_b;
`ifdef PTL_ARB_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_a, cyc_b;
  bit   cnt_mode = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  ptl_link_arbiter #(
    .N_REQ(4), .GAP_CYCLES(2), .START_CYCLES(8)
  ) u_a (
    .clk(clk), .rst(rst_a), .req(req_a),
    .grant(g_a), .q(q_a), .busy(busy_a),
`ifdef PTL_ARB_CNT_EN
    .tx_count(cnt_a),
`endif
    .tx_id(id_a)
  );

  ptl_link_arbiter #(
    .N_REQ(4), .GAP_CYCLES(0), .START_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rst_b), .req(req_b),
    .grant(g_b), .q(q_b), .busy(busy_b),
`ifdef PTL_ARB_CNT_EN
    .tx_count(cnt_b),
`endif
    .tx_id(id_b)
  );

  always @(posedge clk or posedge rst_a)
    if (rst_a) cyc_a <= -1;
    else       cyc_a <= cyc_a + 1;

  always @(posedge clk or posedge rst_b)
    if (rst_b) cyc_b <= -1;
    else       cyc_b <= cyc_b + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_a(input int c);
    int n = 0;
    while (cyc_a != c && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_wait_cycle", cyc_a, c);
  endtask

  task automatic wait_b(input int c);
    int n = 0;
    while (cyc_b != c && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_wait_cycle", cyc_b, c);
  endtask

  // Monitors: pop an expectation whenever a grant appears
  always @(negedge clk) begin
    if (rst_a === 1'b0 && g_a !== 4'b0) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_grant", {28'b0, g_a}, 32'b0);
      end else begin
        ea = qa.pop_front();
        chk("a_cycle", cyc_a, ea.cyc);
        chk("a_grant", {28'b0, g_a}, {28'b0, ea.g});
        chk("a_q", {31'b0, q_a}, {31'b0, ea.q});
        chk("a_tx_id", {30'b0, id_a}, {30'b0, ea.id});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b === 1'b0 && !cnt_mode && g_b !== 4'b0) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_grant", {28'b0, g_b}, 32'b0);
      end else begin
        eb = qb.pop_front();
        chk("b_cycle", cyc_b, eb.cyc);
        chk("b_grant", {28'b0, g_b}, {28'b0, eb.g});
        chk("b_q", {31'b0, q_b}, {31'b0, eb.q});
        chk("b_tx_id", {30'b0, id_b}, {30'b0, eb.id});
      end
    end
  end

  task automatic run_a();
    req_a = 4'b0001;
    qa.push_back('{8, 4'b0001, 1'b1, 2'd0});
    @(negedge clk);
    rst_a = 1'b0;
    // start-up blanking: busy low only in the grant cycle
    while (cyc_a < 10) begin
      @(negedge clk);
      chk("a_busy_start", busy_a, cyc_a != 8);
      if (cyc_a == 8) req_a = 4'b0000;
    end
    // round-robin from ptr=1, one grant every 3 cycles
    req_a = 4'b1111;
    qa.push_back('{11, 4'b0010, 1'b0, 2'd1});
    qa.push_back('{14, 4'b0100, 1'b1, 2'd2});
    qa.push_back('{17, 4'b1000, 1'b0, 2'd3});
    qa.push_back('{20, 4'b0001, 1'b1, 2'd0});
    qa.push_back('{23, 4'b0010, 1'b0, 2'd1});
    wait_a(23);
    req_a = 4'b1000;
    wait_a(24);
    req_a = 4'b0000;
    wait_a(26);
    chk("a_busy_idle", busy_a, 0);
    wait_a(27);
    chk("a_q_hold", q_a, 0);
    chk("a_id_hold", id_a, 1);
    chk("a_busy_idle2", busy_a, 0);
    // ptr must still be 2 after the withdrawn req[3]
    req_a = 4'b0101;
    qa.push_back('{28, 4'b0100, 1'b1, 2'd2});
    wait_a(28);
    req_a = 4'b0000;
    wait_a(29);
    chk("a_busy_guard", busy_a, 1);
    chk("a_q_pre_rst", q_a, 1);
    #2 rst_a = 1'b1;
    #1;
    chk("a_rst_q", q_a, 0);
    chk("a_rst_grant", g_a, 0);
    chk("a_rst_busy", busy_a, 1);
    chk("a_rst_id", id_a, 0);
    req_a = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    qa.push_back('{8, 4'b0010, 1'b1, 2'd1});
    rst_a = 1'b0;
    wait_a(3);
    chk("a_warm_id", id_a, 0);
    chk("a_warm_busy", busy_a, 1);
    wait_a(8);
    req_a = 4'b0000;
    wait_a(12);
  endtask

  task automatic run_b();
    req_b = 4'b0101;
    qb.push_back('{0, 4'b0001, 1'b1, 2'd0});
    qb.push_back('{1, 4'b0100, 1'b0, 2'd2});
    qb.push_back('{2, 4'b0001, 1'b1, 2'd0});
    qb.push_back('{3, 4'b0100, 1'b0, 2'd2});
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wait_b(c);
      chk("b_busy", busy_b, 0);
    end
    req_b = 4'b0000;
    wait_b(4);
    chk("b_busy_idle", busy_b, 0);
    chk("b_no_grant", g_b, 0);
`ifdef PTL_ARB_CNT_EN
    chk("b_count4", cnt_b, 4);
    cnt_mode = 1'b1;
    req_b = 4'b0001;
    repeat (70000) @(negedge clk);
    chk("b_count_sat", cnt_b, 16'hFFFF);
    repeat (5) @(negedge clk);
    chk("b_count_hold", cnt_b, 16'hFFFF);
    req_b = 4'b0000;
    repeat (2) @(negedge clk);
    cnt_mode = 1'b0;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_a = 1'b0;
    rst_b = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk("a_reset_grant", g_a, 0);
    chk("a_reset_q", q_a, 0);
    chk("a_reset_busy", busy_a, 1);
    chk("a_reset_id", id_a, 0);
    chk("b_reset_grant", g_b, 0);
    chk("b_reset_q", q_b, 0);
    chk("b_reset_busy", busy_b, 1);
    chk("b_reset_id", id_b, 0);
    fork
      run_a();
      run_b();
    join
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_queue_left", qa.size(), 0);
    chk("b_queue_left", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
